// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : arb_pkg                                                           |
// | Brief  : Shared sizes and FSM state type for the 8-way round-robin arbiter |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/decoder3x8_behav.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : decoder3x8_behav                                                  |
// | Brief  : 3-to-8 decoder with enable; a is the select MSB, c the LSB        |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module decoder3x8_behav
  import arb_pkg::*;
(
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             en,
  output logic [N_REQ-1:0] y
);

  logic [IDX_W-1:0] w_sel;

  assign w_sel = {a, b, c};

  for (genvar i = 0; i < N_REQ; i++) begin : g_out
    assign y[i] = en && (w_sel == IDX_W'(i));
  end

endmodule : decoder3x8_behav
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_arbiter8                                                       |
// | Brief  : 8-way round-robin arbiter driving a 3x8 decoder select/enable.    |
// |          Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles.     |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             dec_a,
  output logic             dec_b,
  output logic             dec_c,
  output logic             dec_en,
  output logic             timeout
);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt_idx;

  logic             w_grant;
  logic             w_any;
  logic             w_drop;
  logic             w_force;
  logic             w_release;
  logic [IDX_W-1:0] w_next_ptr;
  logic [IDX_W-1:0] w_scan_ptr;
  logic [IDX_W-1:0] w_win;

  // First set bit of req_v scanning start, start+1, ... with 3-bit wraparound.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = start + IDX_W'(i);
      if (!found && req_v[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    return pick;
  endfunction

  assign w_grant    = (r_state == ARB_GRANT);
  assign w_any      = |req;
  assign w_next_ptr = r_gnt_idx + IDX_W'(1);
  // Re-arbitration at a release scans from the post-release pointer, so the
  // outgoing grantee is considered last.
  assign w_scan_ptr = w_grant ? w_next_ptr : r_ptr;
  assign w_win      = rr_pick(req, w_scan_ptr);
  assign w_drop     = rel || !req[r_gnt_idx];
  assign w_release  = w_grant && (w_drop || w_force);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  assign w_force = w_grant && !w_drop && (r_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (!w_grant || w_release) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_hold;

  assign w_unused_hold = (MAX_HOLD > 0);
  assign w_force       = 1'b0;
  assign timeout       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      r_gnt_idx <= '0;
    end else if (!w_grant) begin
      if (w_any) begin
        r_gnt_idx <= w_win;
        r_state   <= ARB_GRANT;
      end
    end else if (w_release) begin
      r_ptr <= w_next_ptr;
      if (w_any) begin
        r_gnt_idx <= w_win;
      end else begin
        r_state <= ARB_IDLE;
      end
    end
  end

  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = w_grant;
  assign dec_a     = r_gnt_idx[2];
  assign dec_b     = r_gnt_idx[1];
  assign dec_c     = r_gnt_idx[0];
  assign dec_en    = w_grant;

  decoder3x8_behav u_dec (
    .a  (dec_a),
    .b  (dec_b),
    .c  (dec_c),
    .en (dec_en),
    .y  (gnt)
  );

endmodule : rr_arbiter8
`default_nettype wire
